ps2_key_decoder: RTL and testbench

//  PS/2 keyboard front end: synchronises PS2_CLK/PS2_DAT, deserialises 11-bit frames,

---
 rtl/ps2_key_decoder.sv | 199 +++++++++++++++++++
 tb/tb_ps2_key_decoder.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder
//   PS/2 keyboard front end. Synchronises the raw PS/2 pins, deserialises
//   11-bit frames (start, 8 data LSB first, odd parity, stop), flags parity,
//   framing and timeout errors, then decodes make/break (F0) and extended (E0)
//   prefixes into an 8-key held vector for the tone stage.
// Ports
//   CLOCK_50   in   system clock (only clock in the block)
//   resetn     in   asynchronous active-low reset
//   PS2_CLK    in   raw PS/2 clock pin (asynchronous)
//   PS2_DAT    in   raw PS/2 data pin (asynchronous)
//   scan_code  out  last good byte, held until the next good byte
//   code_valid out  1-cycle pulse when scan_code updates
//   frame_err  out  1-cycle pulse on parity / stop / timeout error
//   key_state  out  held-key vector, bit = 1 while the mapped key is down
module ps2_key_decoder #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic [7:0] scan_code,
    output logic       code_valid,
    output logic       frame_err,
    output logic [7:0] key_state
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    // Synchronisers reset to 1 (bus idle level) so reset release never fakes a fall.
    logic clk_s1_q, clk_s2_q, clk_hist_q;
    logic dat_s1_q, dat_s2_q;
    logic fall;

    state_t          state_q, state_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            par_q, par_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            good_pend_q, good_pend_d;
    logic            bad_pend_q, bad_pend_d;
    logic [7:0]      scan_code_q, scan_code_d;
    logic            code_valid_q, code_valid_d;
    logic            frame_err_q, frame_err_d;
    logic [7:0]      key_state_q, key_state_d;
    logic            brk_pend_q, brk_pend_d;
    logic            ext_pend_q, ext_pend_d;
    logic [7:0]      key_mask;

    assign fall = clk_hist_q & ~clk_s2_q;

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            clk_hist_q <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
        end else begin
            clk_s1_q   <= PS2_CLK;
            clk_s2_q   <= clk_s1_q;
            clk_hist_q <= clk_s2_q;
            dat_s1_q   <= PS2_DAT;
            dat_s2_q   <= dat_s1_q;
        end
    end

    // Frame receiver. A finished frame is reported through good/bad_pend,
    // which the output stage turns into code_valid / frame_err one cycle later.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        par_d       = par_q;
        good_pend_d = 1'b0;
        bad_pend_d  = 1'b0;
        tmo_d       = (state_q == IDLE || fall) ? '0 : tmo_q + TW'(1);

        case (state_q)
            IDLE: begin
                // A fall with data high is not a start bit: treat as a glitch.
                if (fall && !dat_s2_q) begin
                    state_d   = DATA;
                    bit_cnt_d = 3'd0;
                end
            end
            DATA: begin
                if (fall) begin
                    shift_d   = {dat_s2_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = PARITY;
                end
            end
            PARITY: begin
                if (fall) begin
                    par_d   = dat_s2_q;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (fall) begin
                    state_d = IDLE;
                    if (dat_s2_q && (^shift_q ^ par_q)) good_pend_d = 1'b1;
                    else                                bad_pend_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_q != IDLE && !fall && tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
            state_d    = IDLE;
            bad_pend_d = 1'b1;
        end
    end

    function automatic logic [7:0] key_map(input logic [7:0] c);
        case (c)
            8'h1C:   key_map = 8'h01;
            8'h1B:   key_map = 8'h02;
            8'h23:   key_map = 8'h04;
            8'h2B:   key_map = 8'h08;
            8'h34:   key_map = 8'h10;
            8'h33:   key_map = 8'h20;
            8'h3B:   key_map = 8'h40;
            8'h42:   key_map = 8'h80;
            default: key_map = 8'h00;
        endcase
    endfunction

    assign key_mask = key_map(scan_code_q);

    // Output stage and prefix decode. The shift register cannot change in the
    // cycle after STOP (a new frame needs at least two more falls), so it is
    // safe to copy it into scan_code here.
    always_comb begin
        code_valid_d = good_pend_q;
        frame_err_d  = bad_pend_q;
        scan_code_d  = good_pend_q ? shift_q : scan_code_q;
        key_state_d  = key_state_q;
        brk_pend_d   = brk_pend_q;
        ext_pend_d   = ext_pend_q;

        if (code_valid_q) begin
            if (scan_code_q == 8'hF0) begin
                brk_pend_d = 1'b1;
            end else if (scan_code_q == 8'hE0) begin
                ext_pend_d = 1'b1;
            end else begin
                // Extended keys share base codes with the map; never touch key_state for them.
                if (!ext_pend_q) begin
                    key_state_d = brk_pend_q ? (key_state_q & ~key_mask)
                                             : (key_state_q |  key_mask);
                end
                brk_pend_d = 1'b0;
                ext_pend_d = 1'b0;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'h00;
            par_q        <= 1'b0;
            tmo_q        <= '0;
            good_pend_q  <= 1'b0;
            bad_pend_q   <= 1'b0;
            scan_code_q  <= 8'h00;
            code_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            key_state_q  <= 8'h00;
            brk_pend_q   <= 1'b0;
            ext_pend_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_q        <= par_d;
            tmo_q        <= tmo_d;
            good_pend_q  <= good_pend_d;
            bad_pend_q   <= bad_pend_d;
            scan_code_q  <= scan_code_d;
            code_valid_q <= code_valid_d;
            frame_err_q  <= frame_err_d;
            key_state_q  <= key_state_d;
            brk_pend_q   <= brk_pend_d;
            ext_pend_q   <= ext_pend_d;
        end
    end

    assign scan_code  = scan_code_q;
    assign code_valid = code_valid_q;
    assign frame_err  = frame_err_q;
    assign key_state  = key_state_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder. The PS/2 clock runs at 40 system
// cycles per bit and the timeout is shortened to 500 cycles so the whole run
// stays short; the latency and timeout arithmetic is identical at full scale.
module tb_ps2_key_decoder;

    localparam int TMO  = 500;
    localparam int HALF = 20;

    logic       CLOCK_50 = 1'b0;
    logic       resetn   = 1'b0;
    logic       PS2_CLK  = 1'b1;
    logic       PS2_DAT  = 1'b1;
    logic [7:0] scan_code;
    logic       code_valid;
    logic       frame_err;
    logic [7:0] key_state;

    int n_chk  = 0;
    int n_fail = 0;
    int cv_cnt = 0;
    int fe_cnt = 0;
    int both_cnt = 0;
    int cv0, fe0;

    ps2_key_decoder #(.TIMEOUT_CYCLES(TMO)) dut (
        .CLOCK_50   (CLOCK_50),
        .resetn     (resetn),
        .PS2_CLK    (PS2_CLK),
        .PS2_DAT    (PS2_DAT),
        .scan_code  (scan_code),
        .code_valid (code_valid),
        .frame_err  (frame_err),
        .key_state  (key_state)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    // Pulse counters sampled mid-cycle.
    always @(negedge CLOCK_50) begin
        if (code_valid) cv_cnt++;
        if (frame_err)  fe_cnt++;
        if (code_valid && frame_err) both_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLOCK_50);
            #1;
        end
    endtask

    task automatic ps2_bit(input logic b);
        PS2_DAT = b;
        tick(HALF);
        PS2_CLK = 1'b0;
        tick(HALF);
        PS2_CLK = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic flip_par, input logic stop);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(d[i]);
        ps2_bit((~^d) ^ flip_par);
        ps2_bit(stop);
        PS2_DAT = 1'b1;
        tick(10);
    endtask

    initial begin
        logic [7:0] b;

        // Reset state
        tick(3);
        chk("rst_scan", 32'(scan_code), 32'h00);
        chk("rst_ks",   32'(key_state), 32'h00);
        chk("rst_cv",   32'(code_valid), 32'h0);
        chk("rst_fe",   32'(frame_err), 32'h0);
        resetn = 1'b1;
        tick(5);

        // 1: frame 1C, exact latency from the stop-bit fall
        b = 8'h1C;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(1'b0);              // odd parity of 1C (three ones)
        PS2_DAT = 1'b1;
        tick(HALF);
        PS2_CLK = 1'b0;
        tick(3);
        chk("t1_cv_early", 32'(code_valid), 32'h0);
        tick(1);
        chk("t1_cv_lat4", 32'(code_valid), 32'h1);
        chk("t1_scan",    32'(scan_code), 32'h1C);
        chk("t1_ks_pre",  32'(key_state), 32'h00);
        tick(1);
        chk("t1_cv_pulse", 32'(code_valid), 32'h0);
        chk("t1_ks",       32'(key_state), 32'h01);
        tick(HALF - 5);
        PS2_CLK = 1'b1;
        tick(HALF);
        chk("t1_fe_none", 32'(fe_cnt), 32'd0);
        chk("t1_cv_once", 32'(cv_cnt), 32'd1);

        // 2: 1B, F0 1C
        send_frame(8'h1B, 1'b0, 1'b1);
        chk("t2_ks_1b", 32'(key_state), 32'h03);
        cv0 = cv_cnt;
        send_frame(8'hF0, 1'b0, 1'b1);
        chk("t2_f0_cv",   32'(cv_cnt), 32'(cv0 + 1));
        chk("t2_f0_scan", 32'(scan_code), 32'hF0);
        chk("t2_f0_ks",   32'(key_state), 32'h03);
        send_frame(8'h1C, 1'b0, 1'b1);
        chk("t2_brk_ks",  32'(key_state), 32'h02);

        // 3: parity error, then stop error
        cv0 = cv_cnt; fe0 = fe_cnt;
        send_frame(8'h23, 1'b1, 1'b1);
        chk("t3_par_fe",   32'(fe_cnt), 32'(fe0 + 1));
        chk("t3_par_cv",   32'(cv_cnt), 32'(cv0));
        chk("t3_par_ks",   32'(key_state), 32'h02);
        chk("t3_par_scan", 32'(scan_code), 32'h1C);
        send_frame(8'h23, 1'b0, 1'b0);
        chk("t3_stop_fe",  32'(fe_cnt), 32'(fe0 + 2));
        chk("t3_stop_cv",  32'(cv_cnt), 32'(cv0));
        chk("t3_stop_ks",  32'(key_state), 32'h02);

        // 4: 6 data bits then silence -> timeout pulse TMO+4 cycles after last fall
        fe0 = fe_cnt;
        b = 8'h55;
        ps2_bit(1'b0);
        for (int i = 0; i < 6; i++) ps2_bit(b[i]);
        tick(TMO + 3 - HALF);
        chk("t4_fe_early", 32'(frame_err), 32'h0);
        tick(1);
        chk("t4_fe_pulse", 32'(frame_err), 32'h1);
        tick(1);
        chk("t4_fe_end",   32'(frame_err), 32'h0);
        chk("t4_fe_cnt",   32'(fe_cnt), 32'(fe0 + 1));
        send_frame(8'h42, 1'b0, 1'b1);
        chk("t4_ks_42",    32'(key_state), 32'h82);

        // 5: extended codes ignored, flags cleared by the next plain code
        send_frame(8'hE0, 1'b0, 1'b1);
        send_frame(8'h1C, 1'b0, 1'b1);
        chk("t5_e0_make", 32'(key_state), 32'h82);
        send_frame(8'hE0, 1'b0, 1'b1);
        send_frame(8'hF0, 1'b0, 1'b1);
        send_frame(8'h1B, 1'b0, 1'b1);
        chk("t5_e0_brk",  32'(key_state), 32'h82);
        send_frame(8'h2B, 1'b0, 1'b1);
        chk("t5_2b",      32'(key_state), 32'h8A);

        // Typematic repeat, break of unheld key, unmapped code
        send_frame(8'h1C, 1'b0, 1'b1);
        send_frame(8'h1C, 1'b0, 1'b1);
        chk("rep_ks",     32'(key_state), 32'h8B);
        send_frame(8'hF0, 1'b0, 1'b1);
        send_frame(8'h33, 1'b0, 1'b1);
        chk("brk_unheld", 32'(key_state), 32'h8B);
        send_frame(8'h15, 1'b0, 1'b1);
        chk("unmapped",   32'(key_state), 32'h8B);
        chk("unmap_scan", 32'(scan_code), 32'h15);

        // 6: async reset mid-frame; the remainder arrives misaligned and times out
        b = 8'h1B;
        ps2_bit(1'b0);
        for (int i = 0; i < 3; i++) ps2_bit(b[i]);
        resetn = 1'b0;
        #2;
        chk("t6_rst_scan", 32'(scan_code), 32'h00);
        chk("t6_rst_ks",   32'(key_state), 32'h00);
        chk("t6_rst_cv",   32'(code_valid), 32'h0);
        chk("t6_rst_fe",   32'(frame_err), 32'h0);
        tick(2);
        resetn = 1'b1;
        tick(2);
        cv0 = cv_cnt; fe0 = fe_cnt;
        for (int i = 3; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(1'b1);              // parity of 1B
        ps2_bit(1'b1);              // stop
        tick(TMO + 100);
        chk("t6_tmo_fe", 32'(fe_cnt), 32'(fe0 + 1));
        chk("t6_tmo_cv", 32'(cv_cnt), 32'(cv0));
        send_frame(8'h23, 1'b0, 1'b1);
        chk("t6_ks",     32'(key_state), 32'h04);
        chk("t6_scan",   32'(scan_code), 32'h23);

        chk("never_both", 32'(both_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
